// File: rtl/eai_pkg.sv
// Types and constants shared by the EAI ICB blocks (initiator and target side).
// Provides the data/mask widths, default scratchpad base address and response type.
package eai_pkg;

    localparam int          DATA_WIDTH    = 32;
    localparam int          MASK_WIDTH    = DATA_WIDTH / 8;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h1000_0000;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } icb_rsp_t;

endpackage

// File: rtl/icb_rsp_fifo.sv
// In-order synchronous FIFO of ICB response entries.
// Ports: clk/rst, i_push/i_data, i_pop, o_data (head), o_count, o_full, o_empty.
module icb_rsp_fifo
    import eai_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  icb_rsp_t                     i_data,
    input  logic                         i_pop,
    output icb_rsp_t                     o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    icb_rsp_t        r_buf [DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CW-1:0]   r_cnt;
    logic            w_push;
    logic            w_pop;

    // Explicit wrap so non-power-of-two depths work too.
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_data  = r_buf[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= f_next(r_wr);
            if (w_pop)  r_rd <= f_next(r_rd);
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) r_buf[r_wr] <= i_data;
    end

endmodule

// File: rtl/eai_icb_sram_responder.sv
// ICB target serving EAI coprocessor requests from a byte-maskable word SRAM.
// Ports: clk/rst, icb_cmd_* (command in), icb_rsp_* (response out), busy (FIFO non-empty).
module eai_icb_sram_responder
    import eai_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          RSP_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icb_cmd_valid,
    output logic                  icb_cmd_ready,
    input  logic [DATA_WIDTH-1:0] icb_cmd_addr,
    input  logic                  icb_cmd_read,
    input  logic [DATA_WIDTH-1:0] icb_cmd_wdata,
    input  logic [3:0]            icb_cmd_wmask,
    output logic                  icb_rsp_valid,
    input  logic                  icb_rsp_ready,
    output logic [DATA_WIDTH-1:0] icb_rsp_rdata,
    output logic                  icb_rsp_err,
    output logic                  busy
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
    icb_rsp_t              r_hold;

    logic [DATA_WIDTH-1:0] w_off;
    logic [IW-1:0]         w_idx;
    logic                  w_err;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    icb_rsp_t              w_new;
    icb_rsp_t              w_head;
    icb_rsp_t              w_rsp;

    // Depth is a power of two, so any offset bit above the index is out of range.
    assign w_off = icb_cmd_addr - BASE_ADDR;
    assign w_idx = w_off[IW+1:2];
    assign w_err = (icb_cmd_addr < BASE_ADDR)
                || (icb_cmd_addr[1:0] != 2'b00)
                || (w_off[DATA_WIDTH-1:IW+2] != '0);

    // Ready depends only on registered fill level; rst masks it during reset.
    assign icb_cmd_ready = !rst && !w_full;
    assign w_push        = icb_cmd_valid && icb_cmd_ready;
    assign w_pop         = !w_empty && icb_rsp_ready;

    assign w_new.err   = w_err;
    assign w_new.rdata = (!w_err && icb_cmd_read) ? r_mem[w_idx] : '0;

    always_ff @(posedge clk) begin
        if (w_push && !w_err && !icb_cmd_read) begin
            for (int b = 0; b < 4; b++) begin
                if (icb_cmd_wmask[b]) r_mem[w_idx][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
            end
        end
    end

    // Remember the last delivered response so outputs hold while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_pop) begin
            r_hold <= w_head;
        end
    end

    icb_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_new),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_rsp         = w_empty ? r_hold : w_head;
    assign icb_rsp_valid = !w_empty;
    assign icb_rsp_rdata = w_rsp.rdata;
    assign icb_rsp_err   = w_rsp.err;
    assign busy          = (w_count != '0);

endmodule

// File: tb/tb_eai_icb_sram_responder.sv
// Bench for eai_icb_sram_responder: directed vector table, corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_eai_icb_sram_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          NW   = 256;
    localparam int          RD   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic        busy;

    always #5 clk = ~clk;

    eai_icb_sram_responder dut (
        .clk           (clk),
        .rst           (rst),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .busy          (busy)
    );

    typedef struct {
        logic [31:0] d;
        logic        e;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    logic [31:0] mem_m [NW];
    rsp_t        q [$];
    logic [31:0] last_d;
    logic        last_e;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference: a command's response and its effect on memory.
    task automatic model(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                         input logic [3:0] wm, output rsp_t r);
        logic [31:0] off;
        logic        bad;
        off = a - BASE;
        bad = (a < BASE) || (a % 4 != 0) || (off / 4 >= NW);
        r.e = bad;
        r.d = 32'h0;
        if (!bad) begin
            if (rd) begin
                r.d = mem_m[off/4];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (wm[b]) mem_m[off/4][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] a, input logic rd,
                         input logic [31:0] wd, input logic [3:0] wm, input logic rr);
        rsp_t r;
        logic acc;
        @(negedge clk);
        icb_cmd_valid = v;
        icb_cmd_addr  = a;
        icb_cmd_read  = rd;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        icb_rsp_ready = rr;
        #1;
        chk("cmd_ready", icb_cmd_ready, q.size() < RD);
        chk("rsp_valid", icb_rsp_valid, q.size() != 0);
        chk("busy", busy, q.size() != 0);
        if (q.size() != 0) begin
            chk("rsp_rdata", icb_rsp_rdata, q[0].d);
            chk("rsp_err", icb_rsp_err, q[0].e);
        end else begin
            chk("hold_rdata", icb_rsp_rdata, last_d);
            chk("hold_err", icb_rsp_err, last_e);
        end
        acc = v && (q.size() < RD);
        if (q.size() != 0 && rr) begin
            last_d = q[0].d;
            last_e = q[0].e;
            void'(q.pop_front());
        end
        if (acc) begin
            model(a, rd, wd, wm, r);
            q.push_back(r);
            acc_cnt++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, BASE, 1'b1, 32'h0, 4'h0, 1'b1);
    endtask

    vec_t vt [13];

    initial begin
        vt[0]  = '{BASE,          1'b0, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
        vt[1]  = '{BASE,          1'b1, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vt[2]  = '{BASE + 4,      1'b0, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
        vt[3]  = '{BASE + 4,      1'b0, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
        vt[4]  = '{BASE + 4,      1'b1, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
        vt[5]  = '{32'h0FFF_FFFC, 1'b1, 32'h0,         4'h0, 32'h0,         1'b1};
        vt[6]  = '{32'h1000_0400, 1'b1, 32'h0,         4'h0, 32'h0,         1'b1};
        vt[7]  = '{32'h1000_0002, 1'b1, 32'h0,         4'h0, 32'h0,         1'b1};
        vt[8]  = '{32'h1000_0002, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
        vt[9]  = '{BASE,          1'b0, 32'h5555_5555, 4'h0, 32'h0,         1'b0};
        vt[10] = '{BASE,          1'b1, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vt[11] = '{BASE + 32'h3FC, 1'b0, 32'h0BAD_F00D, 4'hF, 32'h0,        1'b0};
        vt[12] = '{BASE + 32'h3FC, 1'b1, 32'h0,        4'h0, 32'h0BAD_F00D, 1'b0};

        rst = 1'b1;
        icb_cmd_valid = 1'b0;
        icb_cmd_addr  = BASE;
        icb_cmd_read  = 1'b1;
        icb_cmd_wdata = 32'h0;
        icb_cmd_wmask = 4'h0;
        icb_rsp_ready = 1'b0;
        last_d = 32'h0;
        last_e = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", icb_cmd_ready, 1'b0);
        chk("rst_rsp_valid", icb_rsp_valid, 1'b0);
        chk("rst_rdata", icb_rsp_rdata, 32'h0);
        chk("rst_err", icb_rsp_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // Directed table: issue, check one cycle later while stalled, then drain.
        foreach (vt[i]) begin
            cycle(1'b1, vt[i].addr, vt[i].rd, vt[i].wd, vt[i].wm, 1'b1);
            @(negedge clk);
            icb_cmd_valid = 1'b0;
            icb_rsp_ready = 1'b0;
            #1;
            chk($sformatf("tbl%0d_valid", i), icb_rsp_valid, 1'b1);
            chk($sformatf("tbl%0d_rdata", i), icb_rsp_rdata, vt[i].exp_d);
            chk($sformatf("tbl%0d_err", i), icb_rsp_err, vt[i].exp_e);
            idle(1);
        end

        // Fill the whole array so later reads have defined contents.
        for (int i = 0; i < NW; i++)
            cycle(1'b1, BASE + 4*i, 1'b0, $urandom, 4'hF, 1'b1);
        idle(2);

        // Back-pressure: four reads with rsp_ready low, only two get in.
        acc_cnt = 0;
        for (int i = 0; i < 4; i++)
            cycle(1'b1, BASE + 4*i, 1'b1, 32'h0, 4'h0, 1'b0);
        chk("bp_accepts", acc_cnt, 2);
        for (int t = 0; t < 20 && !(acc_cnt == 4 && q.size() == 0); t++)
            cycle(acc_cnt < 4, BASE + 4*acc_cnt, 1'b1, 32'h0, 4'h0, 1'b1);
        chk("bp_total", acc_cnt, 4);
        chk("bp_drained", q.size(), 0);

        // Streaming: one read accepted per cycle.
        acc_cnt = 0;
        for (int i = 0; i < 49; i++)
            cycle(1'b1, BASE + 4*i, 1'b1, 32'h0, 4'h0, 1'b1);
        chk("stream_accepts", acc_cnt, 49);
        idle(2);

        // Reset with two responses pending and a command presented.
        cycle(1'b1, BASE + 8, 1'b1, 32'h0, 4'h0, 1'b0);
        cycle(1'b1, BASE + 12, 1'b1, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = BASE + 8;
        icb_cmd_wdata = 32'hFFFF_FFFF;
        icb_cmd_wmask = 4'hF;
        icb_rsp_ready = 1'b1;
        #1;
        chk("midrst_cmd_ready", icb_cmd_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        icb_cmd_valid = 1'b0;
        q.delete();
        last_d = 32'h0;
        last_e = 1'b0;
        #1;
        chk("midrst_rsp_valid", icb_rsp_valid, 1'b0);
        chk("midrst_rdata", icb_rsp_rdata, 32'h0);
        cycle(1'b1, BASE + 8, 1'b1, 32'h0, 4'h0, 1'b1);
        idle(2);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            int          r;
            r = $urandom_range(0, 9);
            if (r < 7)       a = BASE + 4*$urandom_range(0, NW-1);
            else if (r == 7) a = BASE - 4*$urandom_range(1, 4);
            else if (r == 8) a = BASE + 32'h400 + 4*$urandom_range(0, 15);
            else             a = BASE + 4*$urandom_range(0, NW-1) + $urandom_range(1, 3);
            cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 1) == 1,
                  $urandom, 4'($urandom), $urandom_range(0, 2) != 0);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eai_icb_sram_responder.md
# eai_icb_sram_responder

ICB responder (target side) that serves the memory requests issued by EAI coprocessors such as the CNN convolution unit. It owns a word-addressed, byte-maskable SRAM that holds input feature maps and kernels. It accepts ICB commands, executes reads and writes in order, and returns responses through a small in-order response FIFO. It sits between the coprocessor's ICB initiator port and the local scratchpad.

## Interface
Parameters:
- DATA_WIDTH, 32, data and address width
- DEPTH_WORDS, 256, SRAM depth in 32-bit words (power of two)
- BASE_ADDR, 32'h1000_0000, byte address of word 0
- RSP_DEPTH, 2, response FIFO entries (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command accepted when valid & ready
- icb_cmd_addr  in  DATA_WIDTH  byte address
- icb_cmd_read  in  1  1 = read, 0 = write
- icb_cmd_wdata  in  DATA_WIDTH  write data
- icb_cmd_wmask  in  4  byte enables, bit n → byte n
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response consumed when valid & ready
- icb_rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- icb_rsp_err  out  1  address error
- busy  out  1  FIFO non-empty

## Operation
- Accept: on an edge with icb_cmd_valid & icb_cmd_ready.
- Decode: word index = (addr − BASE_ADDR) >> 2. Error if addr < BASE_ADDR, index ≥ DEPTH_WORDS, or addr[1:0] ≠ 0.
- Valid write: update only the bytes enabled in wmask at the acceptance edge. The response carries rdata=0, err=0. wmask=0 leaves the array unchanged and still returns a response.
- Valid read: array read at the acceptance edge. The response carries the word contents, err=0.
- Error: no array access; response rdata=0, err=1.
- Exactly one response per accepted command, in acceptance order.
- Ordering: a read accepted at edge k+1 returns data written at edge k to the same word.
- FIFO: count 0..RSP_DEPTH.
  - Push on accept; pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop leaves count unchanged; output advances to the next entry.
- Full: icb_cmd_ready=0 while count == RSP_DEPTH.
  - cmd_ready has no combinational path from icb_rsp_ready. When full, a same-cycle pop does not enable a same-cycle accept.
- Empty: icb_rsp_valid=0. rsp_rdata and rsp_err are held at their last value, 0 after reset.
- Response fields are stable while rsp_valid=1 and rsp_ready=0.
- FIFO pointers wrap modulo RSP_DEPTH.
- Reset mid-operation: FIFO flushed, count=0, pending responses discarded. A command presented during the reset cycle is not accepted. SRAM contents are not reset.

## Timing
- Reset values: icb_cmd_ready=0 while rst=1, then 1 on the first cycle after rst deasserts. icb_rsp_valid=0, icb_rsp_rdata=0, icb_rsp_err=0, busy=0.
- Latency: command accepted at edge k gives icb_rsp_valid=1 in the cycle after edge k, when the FIFO was empty or popping.
- Throughput: one command per cycle while rsp_ready=1 continuously.
- Back-pressure: with rsp_ready=0, at most RSP_DEPTH commands are accepted. cmd_ready then drops in the cycle after the filling accept.
- No combinational path from any input to any output except through registered state.

## Structure
- Shared package eai_pkg holds:
  - DATA_WIDTH and the wmask width constant
  - ICB response typedef {rdata, err}
  - BASE_ADDR default
  - shared with the initiator-side EAI blocks
- Sub-module icb_rsp_fifo: parameterised synchronous FIFO of response typedef entries with count, full and empty outputs. It has the same clk and rst.
- Top level holds the address decode, the byte-masked SRAM array and the accept logic.

## Test plan
- Reset then write: write 0xDEAD_BEEF to 0x1000_0000 with mask 4'hF, then read 0x1000_0000 → first response rdata=0, err=0; second response rdata=0xDEAD_BEEF, err=0, one cycle after its accept.
- Byte mask: with 0x1000_0004 = 0x1122_3344, write 0xAABB_CCDD with mask 4'b0101, then read → rdata=0x11BB_33DD.
- Errors: read 0x0FFF_FFFC, 0x1000_0400 (DEPTH 256) and 0x1000_0002 → three responses with err=1, rdata=0, and the array is unchanged.
- Back-pressure: rsp_ready=0 with four back-to-back reads → exactly 2 accepted, cmd_ready=0. Raising rsp_ready then drains responses in order with stable data while stalled, and the remaining 2 reads complete.
- Streaming: 49 consecutive reads with rsp_ready=1 → 49 accepts in 49 cycles and responses in address order.
- Reset mid-operation: FIFO holding 2 responses, assert rst for one cycle → rsp_valid=0 next cycle, nothing delivered, and SRAM data still readable afterwards.
